serial_unit_arbiter: RTL
========================

Name: serial_unit_arbiter

Overview:
Shares one bit-serial operand engine (4-bit A/B in, start pulse, done level, 4-bit result) among NUM_REQ requesters. It picks a requester by round-robin and latches that requester's operands. It then launches the engine, waits for done (with a watchdog) and returns the result with a one-cycle ack to the granted requester. It sits between the requester blocks and the single engine instance in the lab datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 4, operand/result width; must match engine width
TIMEOUT, 31, max cycles spent in WAIT before abort (1..255)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  request level per requester; held with stable operands until its ack
a_in  in  NUM_REQ*DATA_W  operand A, requester i at [i*DATA_W +: DATA_W]
b_in  in  NUM_REQ*DATA_W  operand B, same packing
ack  out  NUM_REQ  one-hot, one-cycle pulse: result valid for that requester
result  out  DATA_W  result, valid while any ack bit is high
result_id  out  clog2(NUM_REQ)  index of requester being served
timeout_err  out  1  pulses with ack when the op was aborted
busy  out  1  high in every state except IDLE
eng_start  out  1  one-cycle start pulse to engine
eng_a, eng_b  out  DATA_W  latched operands; stable from GRANT until IDLE
eng_done  in  1  engine completion level
eng_result  in  DATA_W  engine result, sampled when eng_done is seen in WAIT

Behaviour:
- Reset (async, any state, mid-op included): state=IDLE; rr pointer=0; ack=0; result=0; result_id=0; timeout_err=0; busy=0; eng_start=0; eng_a=eng_b=0; watchdog=0. Reset mid-op drops the op with no ack.
- All outputs are registered or decoded from the registered state (Moore). There are no combinational paths from inputs to outputs.
- State encoding and transitions:
  - IDLE: if |req, go to GRANT and latch the winner into result_id. Otherwise stay in IDLE.
  - GRANT: latch eng_a/eng_b from the winner's slice; clear the watchdog. Go to LAUNCH.
  - LAUNCH: eng_start=1 for exactly this cycle. Go to WAIT.
  - WAIT: increment the watchdog each cycle.
    - If eng_done=1, capture eng_result into result and go to RESP.
    - Otherwise, if the watchdog reaches TIMEOUT, set result=0 and timeout_err=1, then go to RESP.
    - If done and timeout occur in the same cycle, done wins.
  - RESP: ack[result_id]=1, plus timeout_err if it was set. Go to IDLE; timeout_err clears on exit.
- Round-robin: the search starts at (last_granted+1) mod NUM_REQ and the first set req bit wins. After reset the pointer is 0, so req[0] has top priority. The pointer updates on the GRANT entry.
- Latency: with req present in IDLE at cycle 0 and eng_done high in the first WAIT cycle (cycle 3), ack is high at cycle 4. Back-to-back ops take 5 cycles plus engine time.
- req changes outside IDLE are ignored. A granted op completes and acks even if its req drops.
- A requester still holding req in the IDLE after its ack is treated as a new request. It is lowest priority at that point.
- eng_done outside WAIT is ignored. eng_done high in the first WAIT cycle is accepted.
- The watchdog is sized ceil(log2(TIMEOUT+1)) bits and does not wrap, because WAIT exits at TIMEOUT.

Decomposition:
- Shared package: state localparams (IDLE, GRANT, LAUNCH, WAIT, RESP; 3-bit), a function computing the requester index width, and TIMEOUT default.
- One sub-module: rr_pick, combinational (req, pointer) -> grant index and valid. It is reusable by other shared-resource arbiters.

Test Plan:
- Single request: the bench engine model alternates AND/OR per bit from bit 0 and asserts done 12 cycles after start. Drive req=4'b0100, a_in slice2=4'b1011, b_in slice2=4'b0110 -> eng_start pulses once, ack=4'b0100, result=4'b1010, result_id=2, timeout_err=0.
- Fairness: hold req=4'b1111 for 8 ops -> grant order 0,1,2,3,0,1,2,3. Each ack is a single pulse, and busy drops for exactly one IDLE cycle between ops.
- Fast engine: eng_done high in the first WAIT cycle -> ack exactly 4 cycles after the IDLE cycle that saw req.
- Timeout: the engine never asserts done, req=4'b0001 -> ack[0] and timeout_err pulse together, TIMEOUT+1 cycles after LAUNCH, with result=0.
- Done in the same cycle as timeout: result=eng_result and timeout_err=0.
- Async reset asserted mid-WAIT -> all outputs 0 immediately, no ack. With req=4'b0011 after release, requester 0 is served first.

Source files
------------

// File: rtl/serial_unit_arbiter_pkg.sv
// Shared definitions for the serial-unit arbiter: FSM state codes and sizing helpers.
package serial_unit_arbiter_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_GRANT  = 3'd1;
    localparam state_t ST_LAUNCH = 3'd2;
    localparam state_t ST_WAIT   = 3'd3;
    localparam state_t ST_RESP   = 3'd4;

    localparam int unsigned TIMEOUT_DEFAULT = 31;

    // Requester index width; a single bit is kept even for two requesters.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 2) ? 32'($clog2(n)) : 32'd1;
    endfunction

    // Watchdog width large enough to hold the timeout value itself.
    function automatic int unsigned wd_w(input int unsigned t);
        return 32'($clog2(t + 1));
    endfunction

endpackage

// File: rtl/serial_unit_arbiter_if.sv
// Requester-side and engine-side signals of the serial-unit arbiter.
interface serial_unit_arbiter_if
    import serial_unit_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 4
);
    localparam int unsigned ID_W = idx_w(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] a_in;
    logic [NUM_REQ*DATA_W-1:0] b_in;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         result;
    logic [ID_W-1:0]           result_id;
    logic                      timeout_err;
    logic                      busy;
    logic                      eng_start;
    logic [DATA_W-1:0]         eng_a;
    logic [DATA_W-1:0]         eng_b;
    logic                      eng_done;
    logic [DATA_W-1:0]         eng_result;

    modport slave (
        input  req, a_in, b_in, eng_done, eng_result,
        output ack, result, result_id, timeout_err, busy, eng_start, eng_a, eng_b
    );

    modport master (
        output req, a_in, b_in, eng_done, eng_result,
        input  ack, result, result_id, timeout_err, busy, eng_start, eng_a, eng_b
    );

endinterface

// File: rtl/serial_unit_arbiter_rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping modulo NUM_REQ.
module serial_unit_arbiter_rr_pick
    import serial_unit_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    grant,
    output logic               valid
);
    localparam int unsigned SUM_W = ID_W + 1;

    logic [NUM_REQ-1:0] rot;
    logic [ID_W-1:0]    off;
    logic [SUM_W-1:0]   sum;

    always_comb begin
        rot = NUM_REQ'({req, req} >> ptr);
        off = '0;
        // Descending scan so the lowest rotated index is the final assignment.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = ID_W'(i);
            end
        end
        sum = SUM_W'(ptr) + SUM_W'(off);
        if (sum >= SUM_W'(NUM_REQ)) begin
            sum = sum - SUM_W'(NUM_REQ);
        end
        grant = sum[ID_W-1:0];
        valid = |req;
    end

endmodule

// File: rtl/serial_unit_arbiter.sv
// Round-robin arbiter sharing one bit-serial engine among NUM_REQ requesters,
// with a watchdog that aborts an op the engine never completes.
module serial_unit_arbiter
    import serial_unit_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input logic                clk,
    input logic                reset,
    serial_unit_arbiter_if.slave bus
);
    localparam int unsigned ID_W = idx_w(NUM_REQ);
    localparam int unsigned WD_W = wd_w(TIMEOUT);

    state_t            state;
    state_t            next_state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   nx_ptr;
    logic [WD_W-1:0]   wd;
    logic [WD_W-1:0]   nx_wd;
    logic [WD_W-1:0]   wd_inc;
    logic              wd_hit;
    logic [ID_W-1:0]   pick_idx;
    logic              pick_valid;
    logic [ID_W-1:0]   nx_result_id;
    logic [NUM_REQ-1:0] nx_ack;
    logic [DATA_W-1:0] nx_result;
    logic [DATA_W-1:0] nx_eng_a;
    logic [DATA_W-1:0] nx_eng_b;
    logic              nx_terr;
    logic              nx_busy;
    logic              nx_start;

    serial_unit_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .grant (pick_idx),
        .valid (pick_valid)
    );

    // Watchdog never wraps: WAIT is left on the cycle the increment reaches TIMEOUT.
    assign wd_inc = wd + WD_W'(1);
    assign wd_hit = (wd_inc == WD_W'(TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (pick_valid) next_state = ST_GRANT;
            ST_GRANT:  next_state = ST_LAUNCH;
            ST_LAUNCH: next_state = ST_WAIT;
            ST_WAIT:   if (bus.eng_done || wd_hit) next_state = ST_RESP;
            ST_RESP:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Next values of every registered output; done takes priority over the watchdog.
    always_comb begin
        nx_ptr       = ptr;
        nx_wd        = wd;
        nx_result_id = bus.result_id;
        nx_result    = bus.result;
        nx_eng_a     = bus.eng_a;
        nx_eng_b     = bus.eng_b;
        nx_ack       = '0;
        nx_terr      = 1'b0;
        nx_start     = 1'b0;
        nx_busy      = (next_state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    nx_result_id = pick_idx;
                    nx_ptr       = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
                end
            end
            ST_GRANT: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (bus.result_id == ID_W'(i)) begin
                        nx_eng_a = bus.a_in[i*DATA_W +: DATA_W];
                        nx_eng_b = bus.b_in[i*DATA_W +: DATA_W];
                    end
                end
                nx_wd    = '0;
                nx_start = 1'b1;
            end
            ST_WAIT: begin
                nx_wd = wd_inc;
                if (bus.eng_done) begin
                    nx_result = bus.eng_result;
                    nx_ack    = NUM_REQ'(1) << bus.result_id;
                end else if (wd_hit) begin
                    nx_result = '0;
                    nx_terr   = 1'b1;
                    nx_ack    = NUM_REQ'(1) << bus.result_id;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr             <= '0;
            wd              <= '0;
            bus.ack         <= '0;
            bus.result      <= '0;
            bus.result_id   <= '0;
            bus.timeout_err <= 1'b0;
            bus.busy        <= 1'b0;
            bus.eng_start   <= 1'b0;
            bus.eng_a       <= '0;
            bus.eng_b       <= '0;
        end else begin
            ptr             <= nx_ptr;
            wd              <= nx_wd;
            bus.ack         <= nx_ack;
            bus.result      <= nx_result;
            bus.result_id   <= nx_result_id;
            bus.timeout_err <= nx_terr;
            bus.busy        <= nx_busy;
            bus.eng_start   <= nx_start;
            bus.eng_a       <= nx_eng_a;
            bus.eng_b       <= nx_eng_b;
        end
    end

endmodule
